worker_pipe: RTL and testbench

WORKER_PIPE -- requirements
Module: worker_pipe

---
 rtl/worker_pipe.sv | 211 +++++++++++++++++++++
 tb/tb_worker_pipe.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/worker_pipe.sv
// Worker pipeline: buffers incoming instruction packets in a small FIFO and issues
// one or two results per packet on a registered valid/ready output port.
module worker_pipe #(
    parameter int PACKET_WIDTH        = 146,
    parameter int WORKER_RESULT_WIDTH = 46,
    parameter int FIFO_DEPTH          = 4,
    parameter bit EXT_OPS             = 1'b1,
    parameter int CNT_WIDTH           = 16
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           RECEIVE_PC_VALID,
    input  logic [PACKET_WIDTH-1:0]        RECEIVE_PC_DATA,
    output logic                           RECEIVE_PC_READY,
    output logic                           SEND_WR_VALID,
    output logic [WORKER_RESULT_WIDTH-1:0] SEND_WR_DATA,
    input  logic                           SEND_WR_READY,
    output logic [$clog2(FIFO_DEPTH):0]    FIFO_LEVEL,
    output logic [CNT_WIDTH-1:0]           RESULT_COUNT,
    output logic                           ERR_OPCODE
);
    // state   | meaning
    // S_IDLE  | nothing on the output; pops and retires illegal packets here
    // S_SEND1 | first (or only) result of the current packet presented
    // S_SEND2 | second result of DISTRIBUTE/SYNC presented
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [3:0] INSN_DISTRIBUTE = 4'd1;
    localparam logic [3:0] INSN_SYNC       = 4'd2;
    localparam logic [3:0] INSN_SWITCH     = 4'd3;
    localparam logic [3:0] INSN_SET_COLOR  = 4'd4;
    localparam logic [3:0] INSN_PLUS       = 4'd5;
    localparam logic [3:0] INSN_MINUS      = 4'd6;
    localparam logic [3:0] INSN_AND        = 4'd7;
    localparam logic [3:0] INSN_OR         = 4'd8;
    localparam logic [3:0] INSN_XOR        = 4'd9;
    localparam logic [3:0] INSN_NZ         = 4'd10;
    localparam logic [3:0] INSN_EQ         = 4'd11;
    localparam logic [3:0] INSN_LT         = 4'd12;
    localparam logic [1:0] OPT_DIRECT      = 2'd0;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [3:0]  color;
        logic [1:0]  opt;
        logic [7:0]  addr;
        logic [31:0] data1;
        logic [31:0] data2;
        logic [31:0] data3;
        logic [31:0] data4;
    } packet_t;

    typedef struct packed {
        logic [1:0]  opt;
        logic [7:0]  addr;
        logic [3:0]  color;
        logic [31:0] data;
    } result_t;

    typedef enum logic [1:0] {S_IDLE, S_SEND1, S_SEND2} state_e;

    localparam int PKT_BITS = $bits(packet_t);

    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            INSN_DISTRIBUTE, INSN_SYNC, INSN_SWITCH, INSN_SET_COLOR,
            INSN_PLUS, INSN_AND, INSN_NZ:                              return 1'b1;
            INSN_MINUS, INSN_OR, INSN_XOR, INSN_EQ, INSN_LT:           return EXT_OPS;
            default:                                                   return 1'b0;
        endcase
    endfunction

    function automatic result_t direct(input logic [31:0] addr, input logic [3:0] color,
                                       input logic [31:0] data);
        return '{opt: OPT_DIRECT, addr: addr[7:0], color: color, data: data};
    endfunction

    function automatic result_t first_result(input packet_t p);
        result_t r;
        r = '{opt: p.opt, addr: p.addr, color: p.color, data: '0};
        case (p.opcode)
            INSN_DISTRIBUTE: r = direct(p.data2, p.color, p.data1);
            INSN_SYNC:       r = direct(p.data3, p.color, p.data1);
            INSN_SWITCH:     r = (p.data2 != '0) ? direct(p.data3, p.color, p.data1)
                                                 : direct(p.data4, p.color, p.data1);
            INSN_SET_COLOR:  r = '{opt: p.opt, addr: p.addr, color: p.data2[3:0], data: p.data1};
            INSN_PLUS:       r.data = p.data1 + p.data2;
            INSN_MINUS:      r.data = p.data1 - p.data2;
            INSN_AND:        r.data = p.data1 & p.data2;
            INSN_OR:         r.data = p.data1 | p.data2;
            INSN_XOR:        r.data = p.data1 ^ p.data2;
            INSN_NZ:         r.data = 32'(p.data1 != '0);
            INSN_EQ:         r.data = 32'(p.data1 == p.data2);
            INSN_LT:         r.data = 32'(p.data1 < p.data2);
            default:         r = '0;
        endcase
        return r;
    endfunction

    function automatic result_t second_result(input packet_t p);
        if (p.opcode == INSN_SYNC) return direct(p.data4, p.color, p.data2);
        return direct(p.data3, p.color, p.data1);
    endfunction

    logic [PACKET_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [LVL_W-1:0]        level, level_nx;
    logic                    rdy_en;
    state_e                  state, state_nx;
    result_t                 second_res;
    logic                    has_second;
    logic                    push, pop, load_first, load_second, clear_valid, set_err, finish;
    logic                    nonempty, send_done, head_legal;
    packet_t                 head;

    assign head             = packet_t'(mem[rd_ptr][PKT_BITS-1:0]);
    assign nonempty         = (level != '0);
    assign head_legal       = is_legal(head.opcode);
    assign send_done        = SEND_WR_VALID && SEND_WR_READY;
    assign RECEIVE_PC_READY = RST && rdy_en && (level != LVL_W'(FIFO_DEPTH));
    assign push             = RECEIVE_PC_VALID && RECEIVE_PC_READY;
    assign FIFO_LEVEL       = level;

    always_comb begin
        state_nx    = state;
        pop         = 1'b0;
        load_first  = 1'b0;
        load_second = 1'b0;
        clear_valid = 1'b0;
        set_err     = 1'b0;
        finish      = 1'b0;
        case (state)
            S_IDLE: begin
                if (nonempty) begin
                    pop = 1'b1;
                    if (head_legal) begin
                        load_first = 1'b1;
                        state_nx   = S_SEND1;
                    end else begin
                        set_err = 1'b1;
                    end
                end
            end
            S_SEND1: begin
                if (send_done) begin
                    if (has_second) begin
                        load_second = 1'b1;
                        state_nx    = S_SEND2;
                    end else begin
                        finish = 1'b1;
                    end
                end
            end
            S_SEND2:  finish = send_done;
            default:  state_nx = S_IDLE;
        endcase
        // An illegal head is left for S_IDLE so it is always retired in its own cycle.
        if (finish) begin
            if (nonempty && head_legal) begin
                pop        = 1'b1;
                load_first = 1'b1;
                state_nx   = S_SEND1;
            end else begin
                clear_valid = 1'b1;
                state_nx    = S_IDLE;
            end
        end
        level_nx = level;
        if (push && !pop)      level_nx = level + LVL_W'(1);
        else if (pop && !push) level_nx = level - LVL_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= RECEIVE_PC_DATA;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            rdy_en        <= 1'b0;
            state         <= S_IDLE;
            SEND_WR_VALID <= 1'b0;
            SEND_WR_DATA  <= '0;
            second_res    <= '0;
            has_second    <= 1'b0;
            RESULT_COUNT  <= '0;
            ERR_OPCODE    <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            level  <= level_nx;
            state  <= state_nx;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (load_first) begin
                SEND_WR_VALID <= 1'b1;
                SEND_WR_DATA  <= WORKER_RESULT_WIDTH'(first_result(head));
                second_res    <= second_result(head);
                has_second    <= (head.opcode == INSN_DISTRIBUTE) || (head.opcode == INSN_SYNC);
            end else if (load_second) begin
                SEND_WR_DATA  <= WORKER_RESULT_WIDTH'(second_res);
            end else if (clear_valid) begin
                SEND_WR_VALID <= 1'b0;
            end
            if (send_done) RESULT_COUNT <= RESULT_COUNT + CNT_WIDTH'(1);
            if (set_err)   ERR_OPCODE   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_worker_pipe.sv
// Scoreboard bench for worker_pipe: stimulus pushes expected results, per-DUT
// monitors pop and compare on each output handshake.
module tb_worker_pipe;
    localparam int PW = 146;
    localparam int RW = 46;

    localparam logic [3:0] DIST = 4'd1, SYNC = 4'd2, SW = 4'd3, SC = 4'd4, PLUS = 4'd5,
                           MINUS = 4'd6, AND_ = 4'd7, OR_ = 4'd8, XOR_ = 4'd9, NZ = 4'd10,
                           EQ = 4'd11, LT = 4'd12, BAD = 4'd15;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_err;
    logic [PW-1:0] a_in_data;
    logic [RW-1:0] a_out_data;
    logic [2:0]    a_level;
    logic [15:0]   a_count;
    logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_err;
    logic [PW-1:0] b_in_data;
    logic [RW-1:0] b_out_data;
    logic [2:0]    b_level;
    logic [15:0]   b_count;

    int            n_total = 0;
    int            n_pass  = 0;
    logic [RW-1:0] qa[$];
    logic [RW-1:0] qb[$];
    logic          a_stall = 1'b0, b_stall = 1'b0;
    logic [RW-1:0] a_hold, b_hold;

    always #5 CLK = ~CLK;

    worker_pipe #(.FIFO_DEPTH(4), .EXT_OPS(1'b1), .CNT_WIDTH(16)) dut_a (
        .CLK(CLK), .RST(RST),
        .RECEIVE_PC_VALID(a_in_valid), .RECEIVE_PC_DATA(a_in_data), .RECEIVE_PC_READY(a_in_ready),
        .SEND_WR_VALID(a_out_valid), .SEND_WR_DATA(a_out_data), .SEND_WR_READY(a_out_ready),
        .FIFO_LEVEL(a_level), .RESULT_COUNT(a_count), .ERR_OPCODE(a_err));

    worker_pipe #(.FIFO_DEPTH(4), .EXT_OPS(1'b0), .CNT_WIDTH(16)) dut_b (
        .CLK(CLK), .RST(RST),
        .RECEIVE_PC_VALID(b_in_valid), .RECEIVE_PC_DATA(b_in_data), .RECEIVE_PC_READY(b_in_ready),
        .SEND_WR_VALID(b_out_valid), .SEND_WR_DATA(b_out_data), .SEND_WR_READY(b_out_ready),
        .FIFO_LEVEL(b_level), .RESULT_COUNT(b_count), .ERR_OPCODE(b_err));

    function automatic logic [PW-1:0] pk(input logic [3:0] op, input logic [3:0] col,
            input logic [1:0] opt, input logic [7:0] addr, input logic [31:0] d1,
            input logic [31:0] d2, input logic [31:0] d3, input logic [31:0] d4);
        return {op, col, opt, addr, d1, d2, d3, d4};
    endfunction

    function automatic logic [RW-1:0] rs(input logic [1:0] opt, input logic [7:0] addr,
            input logic [3:0] col, input logic [31:0] v);
        return {opt, addr, col, v};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (RST) begin
            if (a_stall && a_out_valid) check("hold_a", a_out_data, a_hold);
            if (a_out_valid && a_out_ready) begin
                if (qa.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_a: got %h expected no result", a_out_data);
                end else check("result_a", a_out_data, qa.pop_front());
            end
            a_stall = a_out_valid && !a_out_ready;
            a_hold  = a_out_data;
        end else a_stall = 1'b0;
    end

    always @(negedge CLK) begin
        if (RST) begin
            if (b_stall && b_out_valid) check("hold_b", b_out_data, b_hold);
            if (b_out_valid && b_out_ready) begin
                if (qb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_b: got %h expected no result", b_out_data);
                end else check("result_b", b_out_data, qb.pop_front());
            end
            b_stall = b_out_valid && !b_out_ready;
            b_hold  = b_out_data;
        end else b_stall = 1'b0;
    end

    task automatic send(input bit sel, input logic [PW-1:0] p);
        bit ok = 1'b0;
        if (sel) begin b_in_valid = 1'b1; b_in_data = p; end
        else     begin a_in_valid = 1'b1; a_in_data = p; end
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge CLK);
            ok = sel ? b_in_ready : a_in_ready;
            tick();
        end
        if (sel) b_in_valid = 1'b0; else a_in_valid = 1'b0;
        if (!ok) begin
            n_total++;
            $display("FAIL accept_timeout: got no handshake expected accept");
        end
    endtask

    task automatic issue(input bit sel, input logic [PW-1:0] p, input int n,
                         input logic [RW-1:0] e1, input logic [RW-1:0] e2);
        if (n > 0) begin if (sel) qb.push_back(e1); else qa.push_back(e1); end
        if (n > 1) begin if (sel) qb.push_back(e2); else qa.push_back(e2); end
        send(sel, p);
    endtask

    task automatic drain(input bit sel);
        for (int i = 0; i < 200 && (sel ? qb.size() : qa.size()) > 0; i++) tick();
        if ((sel ? qb.size() : qa.size()) > 0) begin
            n_total++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sel ? qb.size() : qa.size());
        end
    endtask

    initial begin
        a_in_valid = 0; a_in_data = '0; a_out_ready = 1'b1;
        b_in_valid = 0; b_in_data = '0; b_out_ready = 1'b1;
        RST = 1'b0;
        repeat (3) tick();
        check("rst_ready", a_in_ready, 0);
        check("rst_valid", a_out_valid, 0);
        check("rst_data", a_out_data, 0);
        check("rst_level", a_level, 0);
        check("rst_count", a_count, 0);
        check("rst_err", a_err, 0);
        RST = 1'b1;
        tick();
        check("ready_after_rst", a_in_ready, 1);

        // PLUS wraps: 0xFFFFFFFF + 2 = 1, valid one cycle after accept
        issue(0, pk(PLUS, 4'h3, 2'd1, 8'h22, 32'hFFFF_FFFF, 32'd2, 0, 0), 1,
              rs(2'd1, 8'h22, 4'h3, 32'd1), '0);
        check("latency_e", a_out_valid, 0);
        tick();
        check("latency_e1", a_out_valid, 1);
        drain(0);
        check("count_plus", a_count, 1);

        // DISTRIBUTE with output stalled
        a_out_ready = 1'b0;
        issue(0, pk(DIST, 4'h5, 2'd0, 8'h00, 32'd7, 32'hA, 32'hB, 0), 2,
              rs(2'd0, 8'hA, 4'h5, 32'd7), rs(2'd0, 8'hB, 4'h5, 32'd7));
        repeat (4) tick();
        a_out_ready = 1'b1;
        drain(0);
        check("count_dist", a_count, 3);

        issue(0, pk(SYNC, 4'h2, 2'd0, 8'h00, 32'd5, 32'd6, 32'h10, 32'h11), 2,
              rs(2'd0, 8'h10, 4'h2, 32'd5), rs(2'd0, 8'h11, 4'h2, 32'd6));
        issue(0, pk(SW, 4'h1, 2'd0, 8'h00, 32'd9, 32'd1, 32'h20, 32'h21), 1,
              rs(2'd0, 8'h20, 4'h1, 32'd9), '0);
        issue(0, pk(SW, 4'h1, 2'd0, 8'h00, 32'd9, 32'd0, 32'h20, 32'h21), 1,
              rs(2'd0, 8'h21, 4'h1, 32'd9), '0);
        issue(0, pk(SC, 4'h3, 2'd2, 8'h55, 32'hDEAD, 32'h1A, 0, 0), 1,
              rs(2'd2, 8'h55, 4'hA, 32'hDEAD), '0);
        issue(0, pk(MINUS, 4'h4, 2'd1, 8'h66, 32'd0, 32'd1, 0, 0), 1,
              rs(2'd1, 8'h66, 4'h4, 32'hFFFF_FFFF), '0);
        issue(0, pk(AND_, 4'h6, 2'd3, 8'h77, 32'hF0F0, 32'h0FF0, 0, 0), 1,
              rs(2'd3, 8'h77, 4'h6, 32'h00F0), '0);
        issue(0, pk(OR_, 4'h7, 2'd0, 8'h01, 32'hF000, 32'h000F, 0, 0), 1,
              rs(2'd0, 8'h01, 4'h7, 32'hF00F), '0);
        issue(0, pk(XOR_, 4'h8, 2'd1, 8'h02, 32'hFF00, 32'h0FF0, 0, 0), 1,
              rs(2'd1, 8'h02, 4'h8, 32'hF0F0), '0);
        issue(0, pk(BAD, 4'h9, 2'd0, 8'h03, 32'd1, 32'd1, 0, 0), 0, '0, '0);
        issue(0, pk(NZ, 4'h9, 2'd0, 8'h03, 32'd0, 32'd0, 0, 0), 1,
              rs(2'd0, 8'h03, 4'h9, 32'd0), '0);
        issue(0, pk(NZ, 4'h9, 2'd0, 8'h04, 32'd5, 32'd0, 0, 0), 1,
              rs(2'd0, 8'h04, 4'h9, 32'd1), '0);
        issue(0, pk(EQ, 4'hA, 2'd0, 8'h05, 32'd9, 32'd9, 0, 0), 1,
              rs(2'd0, 8'h05, 4'hA, 32'd1), '0);
        issue(0, pk(LT, 4'hB, 2'd0, 8'h06, 32'd2, 32'd3, 0, 0), 1,
              rs(2'd0, 8'h06, 4'hB, 32'd1), '0);
        issue(0, pk(LT, 4'hB, 2'd0, 8'h07, 32'hFFFF_FFFF, 32'd1, 0, 0), 1,
              rs(2'd0, 8'h07, 4'hB, 32'd0), '0);
        drain(0);
        check("err_sticky", a_err, 1);
        check("count_ops", a_count, 17);

        // Fill: one packet in the output register plus four buffered
        a_out_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            issue(0, pk(PLUS, 4'h1, 2'd0, 8'h40, 32'(i), 32'd100, 0, 0), 1,
                  rs(2'd0, 8'h40, 4'h1, 32'(100 + i)), '0);
        check("full_ready", a_in_ready, 0);
        check("full_level", a_level, 4);
        a_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("b2b_valid", a_out_valid, 1);
            tick();
        end
        check("b2b_pending", qa.size(), 0);
        check("b2b_idle", a_out_valid, 0);
        check("count_fill", a_count, 22);

        // Extended op illegal when EXT_OPS=0
        issue(1, pk(XOR_, 4'h2, 2'd0, 8'h09, 32'd1, 32'd2, 0, 0), 0, '0, '0);
        issue(1, pk(PLUS, 4'h0, 2'd0, 8'h01, 32'd3, 32'd4, 0, 0), 1,
              rs(2'd0, 8'h01, 4'h0, 32'd7), '0);
        drain(1);
        check("b_err", b_err, 1);
        check("b_count", b_count, 1);

        // Reset while the second SYNC result is pending
        a_out_ready = 1'b0;
        issue(0, pk(SYNC, 4'h3, 2'd0, 8'h00, 32'd1, 32'd2, 32'h33, 32'h44), 1,
              rs(2'd0, 8'h33, 4'h3, 32'd1), '0);
        tick();
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        check("send2_valid", a_out_valid, 1);
        RST = 1'b0;
        tick();
        check("mid_rst_valid", a_out_valid, 0);
        check("mid_rst_level", a_level, 0);
        check("mid_rst_ready", a_in_ready, 0);
        RST = 1'b1;
        a_out_ready = 1'b1;
        repeat (10) tick();
        check("post_rst_count", a_count, 0);
        check("post_rst_pending", qa.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
